// File: rtl/float16_mul_arbiter_pkg.sv
// Shared fp16 format constants and sizing helpers for the multiplier arbiter.
package float16_mul_arbiter_pkg;

    localparam int FP16_W          = 16;
    localparam int FP16_EXP_W      = 5;
    localparam int FP16_FRAC_W     = 10;
    localparam int MUL_LATENCY_DEF = 5;
    localparam int NUM_REQ_DEF     = 4;
    localparam int TAG_DEPTH_DEF   = 8;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

    // Tag width is $clog2(NUM_REQ), kept at least one bit wide.
    function automatic int tag_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/float16_mul_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each multiply in flight.
module float16_mul_arbiter_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;

    // Explicit wrap so non-power-of-two depths still cycle through DEPTH slots.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/float16_mul_arbiter.sv
// Round-robin sharing of one pipelined fp16 multiplier among NUM_REQ lanes,
// with an in-order tag FIFO steering each product back to its issuer.
module float16_mul_arbiter
    import float16_mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int TAG_DEPTH   = TAG_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [FP16_W*NUM_REQ-1:0] req_data_a,
    input  logic [FP16_W*NUM_REQ-1:0] req_data_b,
    output logic [NUM_REQ-1:0]        res_valid,
    output logic [FP16_W-1:0]         res_data,
    output logic                      mul_de_in,
    output logic [FP16_W-1:0]         mul_data_a,
    output logic [FP16_W-1:0]         mul_data_b,
    input  logic                      mul_de_out,
    input  logic [FP16_W-1:0]         mul_data_out,
    output logic [3:0]                inflight,
    output logic                      err_orphan
);

    localparam int TAG_W = tag_w(NUM_REQ);
    // A FIFO shallower than the pipeline plus two would throttle a lone streaming lane.
    localparam int FIFO_DEPTH = (TAG_DEPTH < MUL_LATENCY + 2) ? MUL_LATENCY + 2 : TAG_DEPTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fp16_t            w_op_a [NUM_REQ];
    fp16_t            w_op_b [NUM_REQ];
    logic [TAG_W-1:0] r_ptr;
    logic [TAG_W-1:0] w_hi_idx;
    logic [TAG_W-1:0] w_lo_idx;
    logic             w_hi_found;
    logic             w_lo_found;
    logic [TAG_W-1:0] w_grant;
    logic [TAG_W-1:0] w_ptr_next;
    logic             w_xfer;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [TAG_W-1:0] w_pop_tag;
    logic [CNT_W-1:0] w_count;

    fp16_t               r_mul_a;
    fp16_t               r_mul_b;
    logic                r_mul_de_in;
    logic [NUM_REQ-1:0]  r_res_valid;
    logic [FP16_W-1:0]   r_res_data;
    logic                r_err_orphan;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_op_a[gi] = req_data_a[FP16_W*gi +: FP16_W];
            assign w_op_b[gi] = req_data_b[FP16_W*gi +: FP16_W];
        end
    endgenerate

    // Two-pass scan: lowest valid index at/above ptr wins, else lowest valid overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = TAG_W'(i);
                if (i >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = TAG_W'(i);
                end
            end
        end
    end

    assign w_grant    = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_xfer     = w_lo_found & ~w_full;
    assign req_ready  = w_xfer ? (NUM_REQ'(1) << w_grant) : '0;
    assign w_ptr_next = (w_grant == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant + TAG_W'(1);
    assign w_pop      = mul_de_out & ~w_empty;

    float16_mul_arbiter_tag_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TAG_W),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_b       (rst_b),
        .i_push      (w_xfer),
        .i_push_data (w_grant),
        .i_pop       (mul_de_out),
        .o_pop_data  (w_pop_tag),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_ptr        <= '0;
            r_mul_de_in  <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_res_valid  <= '0;
            r_res_data   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_mul_de_in <= w_xfer;
            if (w_xfer) begin
                r_ptr   <= w_ptr_next;
                r_mul_a <= w_op_a[w_grant];
                r_mul_b <= w_op_b[w_grant];
            end
            r_res_valid <= w_pop ? (NUM_REQ'(1) << w_pop_tag) : '0;
            if (w_pop) begin
                r_res_data <= mul_data_out;
            end
            if (mul_de_out && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign mul_de_in  = r_mul_de_in;
    assign mul_data_a = r_mul_a;
    assign mul_data_b = r_mul_b;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign err_orphan = r_err_orphan;
    assign inflight   = 4'(w_count);

endmodule

// File: tb/tb_float16_mul_arbiter.sv
// Randomized scoreboard bench for float16_mul_arbiter with a behavioural multiplier.
module tb_float16_mul_arbiter;

    localparam int N     = 4;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_b;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_data_a;
    logic [16*N-1:0] req_data_b;
    logic [N-1:0]    res_valid;
    logic [15:0]     res_data;
    logic            mul_de_in;
    logic [15:0]     mul_data_a;
    logic [15:0]     mul_data_b;
    logic            mul_de_out;
    logic [15:0]     mul_data_out;
    logic [3:0]      inflight;
    logic            err_orphan;

    float16_mul_arbiter #(
        .NUM_REQ     (N),
        .MUL_LATENCY (LAT),
        .TAG_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data_a   (req_data_a),
        .req_data_b   (req_data_b),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .mul_de_in    (mul_de_in),
        .mul_data_a   (mul_data_a),
        .mul_data_b   (mul_data_b),
        .mul_de_out   (mul_de_out),
        .mul_data_out (mul_data_out),
        .inflight     (inflight),
        .err_orphan   (err_orphan)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] vec;
        logic [15:0]  data;
        int           due;
        bit           lat;
    } exp_t;
    typedef struct {
        logic [15:0] data;
        int          due;
    } mul_t;

    exp_t sb[$];
    mul_t mq[$];

    bit          pend [N];
    logic [15:0] pa [N];
    logic [15:0] pb [N];
    logic [15:0] optab [8];
    bit          hold = 1'b0;
    bit          force_orphan = 1'b0;
    bit          lat_on = 1'b1;
    int          release_cnt = 0;
    logic        rst_s = 1'b1;

    function automatic real fp_to_real(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] real_to_fp(input real r);
        logic s;
        int   e;
        real  m;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {s, 5'(e), 10'($rtoi((m - 1.0) * 1024.0 + 0.5))};
    endfunction

    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        return real_to_fp(fp_to_real(a) * fp_to_real(b));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = pend[i];
            req_data_a[16*i +: 16] = pa[i];
            req_data_b[16*i +: 16] = pb[i];
        end
    endtask

    // Advance one clock; requesters granted at that edge drop their request.
    task automatic step();
        logic [N-1:0] g;
        @(negedge clk);
        g = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (g[i]) pend[i] = 1'b0;
        drive();
    endtask

    task automatic fill(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(99) < pct) begin
                pend[i] = 1'b1;
                pa[i]   = optab[$urandom_range(7)];
                pb[i]   = optab[$urandom_range(7)];
            end
        end
        drive();
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
    endtask

    // Behavioural multiplier: fixed latency, optionally withholding its outputs.
    always @(negedge clk) rst_s <= rst_b;
    always @(negedge clk) begin
        if (mul_de_in) mq.push_back('{fp_mul(mul_data_a, mul_data_b), cyc + LAT});
    end
    initial begin : mul_model
        mul_de_out   = 1'b0;
        mul_data_out = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            mul_de_out = 1'b0;
            if (rst_s) begin
                mq.delete();
            end else if (force_orphan) begin
                mul_de_out   = 1'b1;
                mul_data_out = 16'h7BFF;
            end else if (mq.size() > 0 && mq[0].due <= cyc && (!hold || release_cnt > 0)) begin
                if (hold) release_cnt--;
                mul_de_out   = 1'b1;
                mul_data_out = mq[0].data;
                void'(mq.pop_front());
            end
        end
    end

    // Reference arbiter: next valid requester after the last one served, FIFO-bounded.
    initial begin : ref_model
        int           last;
        int           cnt;
        bit           merr;
        int           g;
        int           idx;
        bit           pop;
        logic [N-1:0] exp_ready;
        last = N - 1;
        cnt  = 0;
        merr = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_b) begin
                last = N - 1;
                cnt  = 0;
                merr = 1'b0;
                sb.delete();
            end else begin
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (last + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                exp_ready = '0;
                if (g >= 0 && cnt < DEPTH) exp_ready[g] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
                chk("inflight", 32'(inflight), 32'(cnt));
                chk("err_orphan", 32'(err_orphan), 32'(merr));
                pop = mul_de_out && cnt > 0;
                if (mul_de_out && cnt == 0) merr = 1'b1;
                if (exp_ready != '0) begin
                    sb.push_back('{exp_ready, fp_mul(req_data_a[16*g +: 16], req_data_b[16*g +: 16]),
                                   cyc + 7, lat_on});
                    last = g;
                    cnt++;
                end
                if (pop) cnt--;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].lat && cyc > sb[0].due) begin
                chk("res_missing", 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
            end
            if (res_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("res_unexpected", 32'(res_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("res_valid", 32'(res_valid), 32'(e.vec));
                    chk("res_data", 32'(res_data), 32'(e.data));
                    if (e.lat) chk("res_latency", 32'(cyc), 32'(e.due));
                    $display("result vec=%b data=0x%04h cycle=%0d", res_valid, res_data, cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        optab[0] = 16'h3C00; optab[1] = 16'h4000; optab[2] = 16'h3E00; optab[3] = 16'h3800;
        optab[4] = 16'hC000; optab[5] = 16'h4200; optab[6] = 16'hBC00; optab[7] = 16'h3400;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
        rst_b = 1'b1;
        drive();
        repeat (3) step();
        rst_b = 1'b0;
        step();
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data", 32'(res_data), 32'h0);
        chk("rst_mul_de_in", 32'(mul_de_in), 32'h0);
        chk("rst_mul_data_a", 32'(mul_data_a), 32'h0);
        chk("rst_mul_data_b", 32'(mul_data_b), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);

        // Single request: 1.0 x 2.0
        set_req(0, 16'h3C00, 16'h4000);
        #2;
        chk("single_ready", 32'(req_ready), 32'h1);
        step();
        #2;
        chk("single_de_in", 32'(mul_de_in), 32'h1);
        chk("single_mul_a", 32'(mul_data_a), 32'h3C00);
        chk("single_mul_b", 32'(mul_data_b), 32'h4000);
        repeat (10) step();

        // Fairness: every requester valid continuously for 8 cycles
        for (int c = 0; c < 8; c++) begin
            fill(100);
            step();
        end
        clear_all();
        repeat (10) step();

        // Routing on consecutive cycles
        set_req(1, 16'h3E00, 16'h4000);
        step();
        set_req(2, 16'hC000, 16'h3800);
        repeat (12) step();

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            fill(40);
            step();
        end
        clear_all();
        repeat (15) step();

        // Full FIFO with the multiplier withholding its outputs
        lat_on = 1'b0;
        hold   = 1'b1;
        for (int c = 0; c < 12; c++) begin
            fill(100);
            step();
        end
        fill(100);
        #2;
        chk("full_inflight", 32'(inflight), 32'd8);
        chk("full_ready", 32'(req_ready), 32'h0);
        release_cnt = 1;
        step();
        fill(100);
        step();
        fill(100);
        #2;
        chk("release_inflight", 32'(inflight), 32'd7);
        chk("release_resume", 32'(req_ready != '0), 32'h1);
        clear_all();
        hold = 1'b0;
        repeat (20) step();
        lat_on = 1'b1;

        // Orphan de_out with nothing in flight
        chk("orphan_pre_inflight", 32'(inflight), 32'h0);
        #2;
        force_orphan = 1'b1;
        step();
        #2;
        force_orphan = 1'b0;
        step();
        #2;
        chk("orphan_set", 32'(err_orphan), 32'h1);
        repeat (4) step();
        #2;
        chk("orphan_sticky", 32'(err_orphan), 32'h1);
        chk("orphan_no_res", 32'(res_valid), 32'h0);

        // Reset with three products in flight
        set_req(0, 16'h4000, 16'h4200);
        set_req(1, 16'h3800, 16'h3800);
        set_req(2, 16'hBC00, 16'h3E00);
        repeat (3) step();
        rst_b = 1'b1;
        clear_all();
        step();
        rst_b = 1'b0;
        #2;
        chk("midrst_inflight", 32'(inflight), 32'h0);
        chk("midrst_err", 32'(err_orphan), 32'h0);
        chk("midrst_res_valid", 32'(res_valid), 32'h0);
        chk("midrst_res_data", 32'(res_data), 32'h0);
        chk("midrst_de_in", 32'(mul_de_in), 32'h0);
        chk("midrst_mul_a", 32'(mul_data_a), 32'h0);
        set_req(3, 16'h4000, 16'h4000);
        set_req(1, 16'h3C00, 16'hC000);
        #2;
        chk("post_rst_grant", 32'(req_ready), 32'h2);
        for (int c = 0; c < 4; c++) step();
        clear_all();
        repeat (20) step();

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
